// File: rtl/seq_mult_ctrl_if.sv
// Handshake bundle for the sequential Booth multiplier: operands and start in,
// busy/done status and the registered product out.
interface seq_mult_ctrl_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;

  modport master (output start, output A, output B, input busy, input done, input P);
  modport slave  (input start, input A, input B, output busy, output done, output P);
endinterface

// File: rtl/seq_mult_ctrl.sv
// Signed 4x4 radix-2 Booth multiplier retiring one Booth step per clock.
// A start accepted in IDLE or DONE produces a one-cycle done pulse four edges later.
module seq_mult_ctrl (
  input logic            clk,
  input logic            rst,
  seq_mult_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [3:0] mcand;
  logic [8:0] acc;
  logic       booth_bit;
  logic [1:0] step_cnt;
  logic [7:0] p_q;
  logic       busy_q;
  logic       done_q;

  logic [4:0] upper_next;
  logic [8:0] acc_next;

  // One Booth step: the upper half is sign-extended to 5 bits so that -8
  // operands never overflow, then the whole register shifts right arithmetically.
  always_comb begin
    upper_next = acc[8:4];
    case ({acc[0], booth_bit})
      2'b01:   upper_next = acc[8:4] + {mcand[3], mcand};
      2'b10:   upper_next = acc[8:4] - {mcand[3], mcand};
      default: upper_next = acc[8:4];
    endcase
    acc_next = {upper_next[4], upper_next, acc[3:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      booth_bit <= 1'b0;
      step_cnt  <= '0;
      p_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          acc       <= acc_next;
          booth_bit <= acc[0];
          if (step_cnt == 2'd3) begin
            state    <= DONE;
            p_q      <= acc_next[7:0];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            step_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + 2'd1;
          end
        end
        // IDLE and DONE both accept a new request, giving back-to-back operation
        default: begin
          if (bus.start) begin
            state     <= CALC;
            mcand     <= bus.A;
            acc       <= {5'b00000, bus.B};
            booth_bit <= 1'b0;
            step_cnt  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = p_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: directed literal vectors plus a
// cycle-level model built from plain signed multiplication.
module tb_seq_mult_ctrl;

  logic clk;
  logic rst;
  seq_mult_ctrl_if bus ();

  seq_mult_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  int         rem = 0;
  logic [7:0] pending = '0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic [7:0] exp_p = '0;

  // Reference: an accepted start yields busy for four cycles, then one done
  // cycle carrying the signed product of the operands seen at the start edge.
  always @(posedge clk) begin
    if (rst) begin
      rem      <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_p    <= '0;
    end else if (rem > 0) begin
      rem      <= rem - 1;
      exp_busy <= (rem > 1);
      exp_done <= (rem == 1);
      if (rem == 1) exp_p <= pending;
    end else if (bus.start) begin
      rem      <= 4;
      pending  <= 8'(int'($signed(bus.A)) * int'($signed(bus.B)));
      exp_busy <= 1'b1;
      exp_done <= 1'b0;
    end else begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("busy", {7'd0, bus.busy}, {7'd0, exp_busy});
      checkOutput("done", {7'd0, bus.done}, {7'd0, exp_done});
      checkOutput("P", bus.P, exp_p);
      checkOutput("busy_done_excl", {7'd0, bus.busy & bus.done}, 8'd0);
    end
  end

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] exp_prod, input string name);
    int lat;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 4'($urandom);
    bus.B     = 4'($urandom);
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, " latency"}, 8'(lat), 8'd4);
    checkOutput({name, " P"}, bus.P, exp_prod);
  endtask

  logic [3:0] ta [10] = '{4'h0, 4'h1, 4'h9, 4'h9, 4'h9, 4'h8, 4'h2, 4'h8, 4'h8, 4'h7};
  logic [3:0] tb_ [10] = '{4'hD, 4'hD, 4'h9, 4'hF, 4'h7, 4'h0, 4'h7, 4'h8, 4'h7, 4'h7};
  logic [7:0] tp [10] = '{8'h00, 8'hFD, 8'h31, 8'h07, 8'hCF, 8'h00, 8'h0E, 8'h40, 8'hC8, 8'h31};

  logic [3:0] bba [3] = '{4'h3, 4'hB, 4'h8};
  logic [3:0] bbb [3] = '{4'h4, 4'h6, 4'hF};
  logic [7:0] bbp [3] = '{8'h0C, 8'hE2, 8'h08};

  initial begin
    int busy_cnt, done_cnt, idx, last;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {7'd0, bus.busy}, 8'd0);
    checkOutput("reset done", {7'd0, bus.done}, 8'd0);
    checkOutput("reset P", bus.P, 8'h00);
    checking = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus(ta[i], tb_[i], tp[i], $sformatf("table%0d", i));

    // Start held during CALC must neither restart nor queue a second multiply
    bus.A = 4'h3; bus.B = 4'hE; bus.start = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      if (i < 4) begin
        bus.A = 4'($urandom);
        bus.B = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    checkOutput("ignored busy cycles", 8'(busy_cnt), 8'd4);
    checkOutput("ignored done count", 8'(done_cnt), 8'd1);
    checkOutput("ignored P", bus.P, 8'hFA);

    // Back-to-back with start held high, new operands presented in each DONE cycle
    bus.A = bba[0]; bus.B = bbb[0]; bus.start = 1'b1;
    idx = 0; last = 0;
    for (int i = 0; i < 40 && idx < 3; i++) begin
      @(negedge clk);
      if (bus.done) begin
        checkOutput($sformatf("b2b%0d P", idx), bus.P, bbp[idx]);
        checkOutput($sformatf("b2b%0d gap", idx), 8'(i - last), (idx == 0) ? 8'd4 : 8'd5);
        last = i;
        idx++;
        if (idx < 3) begin
          bus.A = bba[idx];
          bus.B = bbb[idx];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b results", 8'(idx), 8'd3);
    repeat (2) @(negedge clk);

    // Reset in the second CALC cycle aborts the multiply without a done pulse
    bus.A = 4'h5; bus.B = 4'h3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", {7'd0, bus.busy}, 8'd0);
    checkOutput("abort done", {7'd0, bus.done}, 8'd0);
    checkOutput("abort P", bus.P, 8'h00);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      done_cnt += int'(bus.done);
    end
    checkOutput("abort no done", 8'(done_cnt), 8'd0);
    applyStimulus(4'hD, 4'h5, 8'hF1, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      bus.start = 1'($urandom);
      bus.A     = 4'($urandom);
      bus.B     = 4'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    checking = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request to begin a multiply, sampled on the rising edge of clk.
REQ-005 A  input  4  multiplicand, two's complement signed.
REQ-006 B  input  4  multiplier, two's complement signed.
REQ-007 busy  output  1  high while a multiply is in progress (state CALC).
REQ-008 done  output  1  one-cycle pulse marking P as newly valid.
REQ-009 P  output  8  signed product A*B, two's complement, registered.

Function
REQ-010 The block SHALL compute P = A*B using a radix-2 Booth shift-add datapath with one Booth step per clock, not a single-cycle combinational multiply.
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE or DONE, when start=1 at edge k, the block SHALL capture A and B into internal registers and enter CALC with the step counter at 0, even if A and B change afterwards.
REQ-013 In IDLE or DONE, when start=0, the block SHALL go to IDLE.
REQ-014 In CALC, the block SHALL perform one Booth step per edge on a 9-bit accumulator/multiplier register plus a 1-bit Booth bit:
  - pair 01: add the sign-extended multiplicand to the upper half;
  - pair 10: subtract the sign-extended multiplicand from the upper half;
  - then arithmetic right shift by one.
REQ-015 Booth arithmetic SHALL use a 5-bit sign-extended upper half so that A=-8 or B=-8 produces no overflow.
REQ-016 On edge k+4, after the fourth step, the block SHALL load the result into P and enter DONE.
REQ-017 done SHALL be 1 only in DONE, i.e. exactly one cycle, between edges k+4 and k+5.
REQ-018 busy SHALL be 1 only in CALC, i.e. between edges k and k+4, and 0 in DONE and IDLE.
REQ-019 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 start=1 in DONE SHALL begin a new multiply at that edge, giving a back-to-back throughput of one result per 5 cycles.
REQ-021 P SHALL hold its last value through IDLE and CALC and change only at the edge entering DONE.
REQ-022 A zero operand SHALL still take the full 4 CALC cycles; there is no early termination.
REQ-023 The step counter SHALL be 2 bits and SHALL NOT wrap into a fifth step.

Reset
REQ-024 When rst=1 at an edge, the block SHALL enter IDLE and clear the operand registers, accumulator, counter, P=8'h00, busy=0 and done=0.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst asserted during CALC or DONE SHALL abort the multiply, produce no done pulse and set P=0.
REQ-027 After rst deasserts, the first start SHALL be accepted in the cycle after the reset edge.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
  - Basic table: start with (A,B) = (0,-3), (1,-3), (-7,-7), (-7,-1), (-7,7), (-8,0), (2,7) -> done pulses 4 edges after the start edge with P = 00, FD, 31, 07, CF, 00, 0E hex respectively.
  - Corner operands: (-8,-8) -> P=8'h40; (-8,7) -> P=8'hC8; (7,7) -> P=8'h31.
  - Ignored start: start pulsed every cycle during CALC -> only one done, busy stays high for exactly 4 cycles, and P reflects the first operands only.
  - Back-to-back: start held high continuously with operands changed each DONE cycle -> done every 5th cycle, each P matching the operands captured at its start edge.
  - Reset mid-operation: rst at the second CALC cycle -> next cycle busy=0, done=0, P=00, no done pulse follows, and a fresh start then completes correctly.
  - Random: 1000 random (A,B,start) samples checked against a signed reference model; done and busy are never high in the same cycle.
